// File: rtl/instruction_fetch_if.sv
// Instruction memory port between the fetch unit (master) and memory (slave).
interface instruction_fetch_if;
  logic [31:0] mem_address;
  logic        mem_readEnable;
  logic        mem_busy;
  logic [31:0] mem_dataRead;
  logic        mem_error;

  modport master (
    output mem_address,
    output mem_readEnable,
    input  mem_busy,
    input  mem_dataRead,
    input  mem_error
  );

  modport slave (
    input  mem_address,
    input  mem_readEnable,
    output mem_busy,
    output mem_dataRead,
    output mem_error
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one read per instruction, holds the returned word
// until the execute stage consumes it, and drops stale words on a flush.
//
// Memory handshake: a read is requested while mem_readEnable is high; the
// address is held stable until the first cycle in which mem_busy is low,
// which is the cycle mem_dataRead and mem_error are valid. A request, once
// issued, is always carried to completion (DISCARD absorbs a flushed one).
module instruction_fetch #(
  parameter logic [31:0] RESET_INSTRUCTION = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [31:0]                fetchAddress,
  input  logic                       flush,
  input  logic                       consume,
  instruction_fetch_if.master        mem,
  output logic [31:0]                fetch_instruction,
  output logic [31:0]                fetch_programCounter,
  output logic                       fetch_valid,
  output logic                       fetch_busError,
  output logic                       fetch_misaligned,
  output logic                       fetch_stall,
  output logic [1:0]                 debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t state;

  assign fetch_stall = !fetch_valid;
  assign debug_state = state;

  // Fetch FSM with all memory-side and fetch-side outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      mem.mem_address      <= 32'd0;
      mem.mem_readEnable   <= 1'b0;
      fetch_instruction    <= RESET_INSTRUCTION;
      fetch_programCounter <= 32'd0;
      fetch_valid          <= 1'b0;
      fetch_busError       <= 1'b0;
      fetch_misaligned     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !flush) begin
            if (fetchAddress[1:0] == 2'b00) begin
              mem.mem_address    <= fetchAddress;
              mem.mem_readEnable <= 1'b1;
              state              <= WAIT;
            end else begin
              // Misaligned target: report a fault without touching memory.
              fetch_instruction    <= RESET_INSTRUCTION;
              fetch_programCounter <= fetchAddress;
              fetch_valid          <= 1'b1;
              fetch_misaligned     <= 1'b1;
              fetch_busError       <= 1'b0;
              state                <= HOLD;
            end
          end
        end

        WAIT: begin
          if (flush) begin
            // Completing and flushing in the same cycle needs no DISCARD.
            if (!mem.mem_busy) begin
              mem.mem_readEnable <= 1'b0;
              state              <= IDLE;
            end else begin
              state <= DISCARD;
            end
          end else if (!mem.mem_busy) begin
            fetch_instruction    <= mem.mem_error ? RESET_INSTRUCTION : mem.mem_dataRead;
            fetch_programCounter <= mem.mem_address;
            fetch_busError       <= mem.mem_error;
            fetch_misaligned     <= 1'b0;
            fetch_valid          <= 1'b1;
            mem.mem_readEnable   <= 1'b0;
            state                <= HOLD;
          end
        end

        HOLD: begin
          // Flush and consume both release the entry; the result is the same.
          if (flush || consume) begin
            fetch_valid       <= 1'b0;
            fetch_busError    <= 1'b0;
            fetch_misaligned  <= 1'b0;
            fetch_instruction <= RESET_INSTRUCTION;
            state             <= IDLE;
          end
        end

        DISCARD: begin
          if (!mem.mem_busy) begin
            mem.mem_readEnable <= 1'b0;
            state              <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: scenario tasks with inline checks, plus a
// monitor that pops an expected-entry queue whenever fetch_valid rises.
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] fetchAddress;
  logic        flush;
  logic        consume;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_programCounter;
  logic        fetch_valid;
  logic        fetch_busError;
  logic        fetch_misaligned;
  logic        fetch_stall;
  logic [1:0]  debug_state;

  instruction_fetch_if mem_bus ();

  instruction_fetch #(.RESET_INSTRUCTION(NOP)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .fetchAddress         (fetchAddress),
    .flush                (flush),
    .consume              (consume),
    .mem                  (mem_bus.master),
    .fetch_instruction    (fetch_instruction),
    .fetch_programCounter (fetch_programCounter),
    .fetch_valid          (fetch_valid),
    .fetch_busError       (fetch_busError),
    .fetch_misaligned     (fetch_misaligned),
    .fetch_stall          (fetch_stall),
    .debug_state          (debug_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Expected held entry: {instruction, pc, busError, misaligned}
  logic [65:0] exp_q[$];
  logic [65:0] exp_e;
  logic [65:0] act_e;
  logic        prev_valid = 1'b0;

  // Scoreboard monitor: each new held entry is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && fetch_valid && !prev_valid) begin
      act_e = {fetch_instruction, fetch_programCounter, fetch_busError, fetch_misaligned};
      vectors = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL sb_unexpected: entry %h appeared, none required", act_e);
      end else begin
        exp_e = exp_q.pop_front();
        if (act_e !== exp_e) begin
          miscompares = miscompares + 1;
          $display("FAIL sb_entry: got %h, required %h", act_e, exp_e);
        end
      end
    end
    prev_valid = rst ? 1'b0 : fetch_valid;
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic busy, input logic [31:0] data, input logic err);
    mem_bus.mem_busy     = busy;
    mem_bus.mem_dataRead = data;
    mem_bus.mem_error    = err;
  endtask

  task automatic release_entry();
    consume = 1'b1;
    tick();
    consume = 1'b0;
    vectors = vectors + 1;
    if (fetch_valid !== 1'b0 || fetch_stall !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL release: valid=%b stall=%b, required 0/1", fetch_valid, fetch_stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0; fetchAddress = 32'd0; flush = 1'b0; consume = 1'b0;
    set_mem(1'b0, 32'd0, 1'b0);
    #3;
    vectors = vectors + 1;
    if ({mem_bus.mem_readEnable, mem_bus.mem_address, fetch_valid, fetch_busError,
         fetch_misaligned, fetch_instruction, fetch_programCounter, fetch_stall}
        !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b0, NOP, 32'd0, 1'b1}) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_values: re=%b addr=%h v=%b be=%b mis=%b ins=%h pc=%h st=%b",
               mem_bus.mem_readEnable, mem_bus.mem_address, fetch_valid, fetch_busError,
               fetch_misaligned, fetch_instruction, fetch_programCounter, fetch_stall);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors = vectors + 1;
    if (debug_state !== 2'd0 || mem_bus.mem_readEnable !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_idle: state=%0d re=%b, required 0/0", debug_state, mem_bus.mem_readEnable);
    end
  endtask

  task automatic test_zero_wait();
    enable = 1'b1; fetchAddress = 32'h100;
    set_mem(1'b0, 32'h00A0_0093, 1'b0);
    exp_q.push_back({32'h00A0_0093, 32'h100, 1'b0, 1'b0});
    tick();
    enable = 1'b0;
    vectors = vectors + 1;
    if (mem_bus.mem_readEnable !== 1'b1 || mem_bus.mem_address !== 32'h100 || fetch_valid !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL zw_request: re=%b addr=%h v=%b, required 1/100/0",
               mem_bus.mem_readEnable, mem_bus.mem_address, fetch_valid);
    end
    tick();
    vectors = vectors + 1;
    if (fetch_valid !== 1'b1 || fetch_stall !== 1'b0 || mem_bus.mem_readEnable !== 1'b0 ||
        fetch_instruction !== 32'h00A0_0093 || fetch_programCounter !== 32'h100) begin
      miscompares = miscompares + 1;
      $display("FAIL zw_capture: v=%b st=%b re=%b ins=%h pc=%h", fetch_valid, fetch_stall,
               mem_bus.mem_readEnable, fetch_instruction, fetch_programCounter);
    end
    @(negedge clk);
    release_entry();
  endtask

  task automatic test_wait_hold();
    logic [31:0] word;
    word = $urandom_range(32'h7FFF_FFFF, 32'h0000_1000) & 32'hFFFF_FF7F;
    enable = 1'b1; fetchAddress = 32'h200;
    set_mem(1'b1, word, 1'b0);
    exp_q.push_back({word, 32'h200, 1'b0, 1'b0});
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors = vectors + 1;
      if (mem_bus.mem_readEnable !== 1'b1 || mem_bus.mem_address !== 32'h200 || fetch_valid !== 1'b0) begin
        miscompares = miscompares + 1;
        $display("FAIL wait_stable[%0d]: re=%b addr=%h v=%b", i, mem_bus.mem_readEnable,
                 mem_bus.mem_address, fetch_valid);
      end
      if (i == 2) mem_bus.mem_busy = 1'b0;
      tick();
    end
    mem_bus.mem_busy = 1'b1;
    mem_bus.mem_dataRead = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      vectors = vectors + 1;
      if (fetch_valid !== 1'b1 || fetch_instruction !== word || mem_bus.mem_readEnable !== 1'b0) begin
        miscompares = miscompares + 1;
        $display("FAIL hold[%0d]: v=%b ins=%h re=%b, required 1/%h/0", i, fetch_valid,
                 fetch_instruction, mem_bus.mem_readEnable, word);
      end
      tick();
    end
    release_entry();
    enable = 1'b1; fetchAddress = 32'h204;
    set_mem(1'b0, 32'h0041_0113, 1'b0);
    exp_q.push_back({32'h0041_0113, 32'h204, 1'b0, 1'b0});
    tick();
    enable = 1'b0;
    vectors = vectors + 1;
    if (mem_bus.mem_readEnable !== 1'b1 || mem_bus.mem_address !== 32'h204) begin
      miscompares = miscompares + 1;
      $display("FAIL next_request: re=%b addr=%h, required 1/204", mem_bus.mem_readEnable, mem_bus.mem_address);
    end
    tick();
    @(negedge clk);
    release_entry();
  endtask

  task automatic test_flush_in_flight();
    enable = 1'b1; fetchAddress = 32'h300;
    set_mem(1'b1, 32'h1111_1111, 1'b0);
    tick();
    enable = 1'b0;
    flush = 1'b1;
    tick();
    vectors = vectors + 1;
    if (debug_state !== 2'd3 || mem_bus.mem_readEnable !== 1'b1 || fetch_valid !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL flush_discard: state=%0d re=%b v=%b, required 3/1/0", debug_state,
               mem_bus.mem_readEnable, fetch_valid);
    end
    for (int i = 0; i < 2; i++) begin
      flush = (i == 1);
      tick();
      vectors = vectors + 1;
      if (mem_bus.mem_readEnable !== 1'b1 || fetch_valid !== 1'b0) begin
        miscompares = miscompares + 1;
        $display("FAIL discard_hold[%0d]: re=%b v=%b, required 1/0", i, mem_bus.mem_readEnable, fetch_valid);
      end
    end
    flush = 1'b0;
    mem_bus.mem_busy = 1'b0;
    tick();
    vectors = vectors + 1;
    if (debug_state !== 2'd0 || mem_bus.mem_readEnable !== 1'b0 || fetch_valid !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL discard_done: state=%0d re=%b v=%b, required 0/0/0", debug_state,
               mem_bus.mem_readEnable, fetch_valid);
    end
    enable = 1'b1; fetchAddress = 32'h400;
    set_mem(1'b0, 32'h0050_0193, 1'b0);
    exp_q.push_back({32'h0050_0193, 32'h400, 1'b0, 1'b0});
    tick();
    enable = 1'b0;
    vectors = vectors + 1;
    if (mem_bus.mem_address !== 32'h400) begin
      miscompares = miscompares + 1;
      $display("FAIL redirect_addr: got %h, required 00000400", mem_bus.mem_address);
    end
    tick();
    @(negedge clk);
    release_entry();
  endtask

  task automatic test_misaligned();
    enable = 1'b1; fetchAddress = 32'h102;
    set_mem(1'b0, 32'h2222_2222, 1'b0);
    exp_q.push_back({NOP, 32'h102, 1'b0, 1'b1});
    tick();
    enable = 1'b0;
    vectors = vectors + 1;
    if (mem_bus.mem_readEnable !== 1'b0 || fetch_valid !== 1'b1 || fetch_misaligned !== 1'b1 ||
        fetch_busError !== 1'b0 || fetch_instruction !== NOP) begin
      miscompares = miscompares + 1;
      $display("FAIL misaligned: re=%b v=%b mis=%b be=%b ins=%h", mem_bus.mem_readEnable,
               fetch_valid, fetch_misaligned, fetch_busError, fetch_instruction);
    end
    @(negedge clk);
    release_entry();
    vectors = vectors + 1;
    if (fetch_misaligned !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL misaligned_clear: got %b, required 0", fetch_misaligned);
    end
  endtask

  task automatic test_bus_error();
    enable = 1'b1; fetchAddress = 32'h500;
    set_mem(1'b0, 32'hFFFF_FFFF, 1'b1);
    exp_q.push_back({NOP, 32'h500, 1'b1, 1'b0});
    tick();
    enable = 1'b0;
    tick();
    set_mem(1'b0, 32'd0, 1'b0);
    vectors = vectors + 1;
    if (fetch_busError !== 1'b1 || fetch_misaligned !== 1'b0 || fetch_instruction !== NOP) begin
      miscompares = miscompares + 1;
      $display("FAIL bus_error: be=%b mis=%b ins=%h, required 1/0/%h", fetch_busError,
               fetch_misaligned, fetch_instruction, NOP);
    end
    @(negedge clk);
    release_entry();
  endtask

  task automatic test_simultaneous();
    enable = 1'b1; fetchAddress = 32'h600;
    set_mem(1'b0, 32'h0060_0213, 1'b0);
    exp_q.push_back({32'h0060_0213, 32'h600, 1'b0, 1'b0});
    tick();
    enable = 1'b0;
    tick();
    @(negedge clk);
    flush = 1'b1; consume = 1'b1;
    tick();
    flush = 1'b0; consume = 1'b0;
    tick();
    vectors = vectors + 1;
    if (fetch_valid !== 1'b0 || debug_state !== 2'd0 || mem_bus.mem_readEnable !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL flush_consume: v=%b state=%0d re=%b, required 0/0/0", fetch_valid,
               debug_state, mem_bus.mem_readEnable);
    end
    // Flush in the same cycle as completion: straight back to IDLE.
    enable = 1'b1; fetchAddress = 32'h640;
    set_mem(1'b0, 32'h3333_3333, 1'b0);
    tick();
    enable = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors = vectors + 1;
    if (debug_state !== 2'd0 || fetch_valid !== 1'b0 || mem_bus.mem_readEnable !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL flush_on_accept: state=%0d v=%b re=%b, required 0/0/0", debug_state,
               fetch_valid, mem_bus.mem_readEnable);
    end
  endtask

  task automatic test_reset_mid_wait();
    enable = 1'b1; fetchAddress = 32'h700;
    set_mem(1'b1, 32'h4444_4444, 1'b0);
    tick();
    enable = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors = vectors + 1;
    if ({mem_bus.mem_readEnable, mem_bus.mem_address, fetch_valid, fetch_instruction,
         fetch_programCounter, fetch_stall, debug_state}
        !== {1'b0, 32'd0, 1'b0, NOP, 32'd0, 1'b1, 2'd0}) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_mid_wait: re=%b addr=%h v=%b ins=%h pc=%h st=%b state=%0d",
               mem_bus.mem_readEnable, mem_bus.mem_address, fetch_valid, fetch_instruction,
               fetch_programCounter, fetch_stall, debug_state);
    end
    tick();
    rst = 1'b0;
    mem_bus.mem_busy = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_hold();
    test_flush_in_flight();
    test_misaligned();
    test_bus_error();
    test_simultaneous();
    test_reset_mid_wait();
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL sb_leftover: %0d entries never appeared, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
